// File: rtl/ftm_ts_capture_ctrl.sv
// rtl/ftm_ts_capture_ctrl.sv - RX/TX FTM timestamp capture into a shared FWFT FIFO; option FTM_TS_WRAP_FLAG_EN adds rd_wrap
module ftm_ts_capture_ctrl #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 8,
    parameter int TIME_W = 48
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [TIME_W-1:0]        ftm_time,
    input  logic                     rx_ts_strobe,
    input  logic [TAG_W-1:0]         rx_tag,
    input  logic                     tx_ts_strobe,
    input  logic [TAG_W-1:0]         tx_tag,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic                     rd_src,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [TIME_W-1:0]        rd_time,
`ifdef FTM_TS_WRAP_FLAG_EN
    output logic                     rd_wrap,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic              rx_v, tx_v;
    logic [TIME_W-1:0] rx_t, tx_t;
    logic [TAG_W-1:0]  rx_g, tx_g;

    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic [TIME_W-1:0] mem_time [DEPTH];
    logic              mem_src  [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic [15:0]       drops;

    logic              flush, pop, wr_req, wr_ok, full_drop, rx_ovr, tx_ovr;
    logic              wr_src;
    logic [TIME_W-1:0] wr_time;
    logic [TAG_W-1:0]  wr_tag;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;

    always_comb begin
        flush     = !rstn || clear;
        pop       = rd_req && (count != '0);
        wr_req    = rx_v || tx_v;
        // RX has fixed priority; a pending TX waits one edge
        wr_src    = !rx_v;
        wr_time   = rx_v ? rx_t : tx_t;
        wr_tag    = rx_v ? rx_g : tx_g;
        wr_ok     = wr_req && ((count != CW'(DEPTH)) || pop);
        full_drop = wr_req && !wr_ok;
        rx_ovr    = enable && rx_ts_strobe && rx_v;
        tx_ovr    = enable && tx_ts_strobe && tx_v;
        drop_inc  = {1'b0, rx_ovr} + {1'b0, tx_ovr} + {1'b0, full_drop};
        drop_sum  = {1'b0, drops} + {15'd0, drop_inc};
        count_next = count;
        if (wr_ok && !pop)
            count_next = count + 1'b1;
        else if (!wr_ok && pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            rx_v   <= 1'b0;
            tx_v   <= 1'b0;
            rx_t   <= '0;
            tx_t   <= '0;
            rx_g   <= '0;
            tx_g   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drops  <= '0;
        end else begin
            // A slot is freed whenever it is scheduled, whether written or dropped
            if (enable && rx_ts_strobe && !rx_v) begin
                rx_v <= 1'b1;
                rx_t <= ftm_time;
                rx_g <= rx_tag;
            end else if (rx_v) begin
                rx_v <= 1'b0;
            end
            if (enable && tx_ts_strobe && !tx_v) begin
                tx_v <= 1'b1;
                tx_t <= ftm_time;
                tx_g <= tx_tag;
            end else if (tx_v && !rx_v) begin
                tx_v <= 1'b0;
            end
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && wr_ok) begin
            mem_tag[wr_ptr]  <= wr_tag;
            mem_time[wr_ptr] <= wr_time;
            mem_src[wr_ptr]  <= wr_src;
        end
    end

`ifdef FTM_TS_WRAP_FLAG_EN
    logic [TIME_W-1:0] last_time;
    logic              mem_wrap [DEPTH];

    always_ff @(posedge clk) begin
        if (flush)
            last_time <= '0;
        else if (wr_ok)
            last_time <= wr_time;
    end

    always_ff @(posedge clk) begin
        if (!flush && wr_ok)
            mem_wrap[wr_ptr] <= (wr_time < last_time);
    end

    assign rd_wrap = rd_valid ? mem_wrap[rd_ptr] : 1'b0;
`endif

    assign rd_valid   = (count != '0);
    assign rd_src     = rd_valid ? mem_src[rd_ptr]  : 1'b0;
    assign rd_tag     = rd_valid ? mem_tag[rd_ptr]  : '0;
    assign rd_time    = rd_valid ? mem_time[rd_ptr] : '0;
    assign fifo_count = count;
    assign drop_cnt   = drops;
endmodule

// File: tb/tb_ftm_ts_capture_ctrl.sv
// tb/tb_ftm_ts_capture_ctrl.sv - scoreboard bench for ftm_ts_capture_ctrl
module tb_ftm_ts_capture_ctrl;
    localparam int DEPTH = 8;
    localparam int TAG_W = 8;
    localparam int TIME_W = 48;

    logic              clk = 1'b0;
    logic              rstn, clear, enable, rx_ts_strobe, tx_ts_strobe, rd_req;
    logic [TIME_W-1:0] ftm_time;
    logic [TAG_W-1:0]  rx_tag, tx_tag;
    logic              rd_valid, rd_src;
    logic [TAG_W-1:0]  rd_tag;
    logic [TIME_W-1:0] rd_time;
    logic [3:0]        fifo_count;
    logic [15:0]       drop_cnt;
`ifdef FTM_TS_WRAP_FLAG_EN
    logic              rd_wrap;
`endif

    ftm_ts_capture_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIME_W(TIME_W)) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .enable(enable), .ftm_time(ftm_time),
        .rx_ts_strobe(rx_ts_strobe), .rx_tag(rx_tag),
        .tx_ts_strobe(tx_ts_strobe), .tx_tag(tx_tag),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_src(rd_src), .rd_tag(rd_tag),
        .rd_time(rd_time),
`ifdef FTM_TS_WRAP_FLAG_EN
        .rd_wrap(rd_wrap),
`endif
        .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                src;
        logic [TAG_W-1:0]  tag;
        logic [TIME_W-1:0] t;
        bit                wrap;
    } ent_t;

    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    // Reference model: pending event per source, expected FIFO contents, counters
    ent_t              exp_q[$];
    int                m_cnt, m_drop, m_d;
    bit                rxv, txv, m_pop, orx, otx;
    ent_t              rxs, txs, e;
    logic [TIME_W-1:0] m_last;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", n, a, x);
        end
    endtask

    always @(posedge clk) begin
        if (!rstn || clear) begin
            exp_q.delete();
            m_cnt = 0; m_drop = 0; rxv = 0; txv = 0; m_last = '0;
        end else begin
            m_pop = rd_req && (m_cnt > 0);
            orx = rxv; otx = txv; m_d = 0;
            if (orx || otx) begin
                e = orx ? rxs : txs;
                if (orx) rxv = 0; else txv = 0;
                if (m_cnt < DEPTH || m_pop) begin
                    e.wrap = (e.t < m_last);
                    m_last = e.t;
                    exp_q.push_back(e);
                    m_cnt++;
                end else begin
                    m_d++;
                end
            end
            if (m_pop) m_cnt--;
            if (enable && rx_ts_strobe) begin
                if (orx) m_d++;
                else begin rxv = 1; rxs.src = 0; rxs.tag = rx_tag; rxs.t = ftm_time; rxs.wrap = 0; end
            end
            if (enable && tx_ts_strobe) begin
                if (otx) m_d++;
                else begin txv = 1; txs.src = 1; txs.tag = tx_tag; txs.t = ftm_time; txs.wrap = 0; end
            end
            m_drop = (m_drop + m_d > 65535) ? 65535 : m_drop + m_d;
        end
    end

    // Monitor: compares the presented head and counters, pops the scoreboard on a read
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_valid", rd_valid, exp_q.size() != 0);
            chk("fifo_count", fifo_count, m_cnt);
            chk("drop_cnt", drop_cnt, m_drop);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL head_unexpected actual=valid expected=empty");
                end else begin
                    chk("rd_src", rd_src, exp_q[0].src);
                    chk("rd_tag", rd_tag, exp_q[0].tag);
                    chk("rd_time", rd_time, exp_q[0].t);
`ifdef FTM_TS_WRAP_FLAG_EN
                    chk("rd_wrap", rd_wrap, exp_q[0].wrap);
`endif
                    if (rd_req) void'(exp_q.pop_front());
                end
            end else begin
                chk("rd_time_empty", rd_time, 0);
                chk("rd_tag_empty", rd_tag, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rx_ts_strobe = 0;
        tx_ts_strobe = 0;
        clear = 0;
    endtask

    initial begin
        rstn = 0; clear = 0; enable = 1; rx_ts_strobe = 0; tx_ts_strobe = 0;
        rd_req = 0; rx_tag = 0; tx_tag = 0; ftm_time = 0;
        tick(); tick();
        chk("reset_valid", rd_valid, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_drop", drop_cnt, 0);
        chk("reset_time", rd_time, 0);
        rstn = 1; mon_en = 1;

        // Lone RX strobe
        ftm_time = 48'h1000; rx_tag = 8'h11; rx_ts_strobe = 1;
        tick();
        chk("t1_valid_N", rd_valid, 0);
        tick();
        chk("t1_valid_N1", rd_valid, 1);
        chk("t1_tag", rd_tag, 8'h11);
        chk("t1_time", rd_time, 48'h1000);
        chk("t1_count", fifo_count, 1);
        rd_req = 1; tick(); rd_req = 0;

        // Simultaneous RX and TX
        ftm_time = 48'h2000; rx_tag = 8'h21; tx_tag = 8'h22;
        rx_ts_strobe = 1; tx_ts_strobe = 1;
        tick(); tick();
        chk("t2_src_rx", rd_src, 0);
        chk("t2_count1", fifo_count, 1);
        tick();
        chk("t2_count2", fifo_count, 2);
        rd_req = 1; tick(); tick(); rd_req = 0;
        chk("t2_drained", fifo_count, 0);

        // Fill to DEPTH plus one overflow, then pop against a pending write
        for (int i = 0; i < 9; i++) begin
            ftm_time = 48'h3000 + 48'(i * 16); rx_tag = 8'(i); rx_ts_strobe = 1;
            tick(); tick();
        end
        chk("t3_full", fifo_count, 8);
        chk("t3_drop", drop_cnt, 1);
        ftm_time = 48'h4000; rx_ts_strobe = 1; tick();
        rd_req = 1; tick(); rd_req = 0;
        chk("t3_count_hold", fifo_count, 8);
        chk("t3_no_drop", drop_cnt, 1);

        // Back-to-back RX while full (full drop + overrun), then disabled TX
        rx_ts_strobe = 1; tick();
        rx_ts_strobe = 1; tick(); tick();
        chk("t4_drop", drop_cnt, 3);
        enable = 0; tx_ts_strobe = 1; tick(); tick(); enable = 1;
        chk("t4_disabled", drop_cnt, 3);

        // Clear while entries are queued
        rd_req = 1; repeat (10) tick(); rd_req = 0;
        for (int i = 0; i < 4; i++) begin
            ftm_time = 48'h5000 + 48'(i); rx_ts_strobe = 1; tick(); tick();
        end
        chk("t5_queued", fifo_count, 4);
        clear = 1; tick();
        chk("t5_valid", rd_valid, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_drop", drop_cnt, 0);
        ftm_time = 48'h6000; tx_ts_strobe = 1; tick(); tick();
        chk("t5_after", rd_valid, 1);
        rd_req = 1; tick(); rd_req = 0;

        // Timebase step backwards
        clear = 1; tick();
        ftm_time = 48'hFFFF_FFFF_FF00; rx_ts_strobe = 1; tick();
        ftm_time = 48'h0100; tx_ts_strobe = 1; tick(); tick();
`ifdef FTM_TS_WRAP_FLAG_EN
        chk("t6_wrap0", rd_wrap, 0);
        rd_req = 1; tick(); rd_req = 0;
        chk("t6_wrap1", rd_wrap, 1);
`endif
        rd_req = 1; tick(); tick(); rd_req = 0;

        // Randomized traffic including resets and clears
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) ftm_time = {16'($urandom()), $urandom()};
            else ftm_time = ftm_time + 48'($urandom_range(1, 20));
            rx_ts_strobe = ($urandom_range(0, 3) == 0);
            tx_ts_strobe = ($urandom_range(0, 3) == 0);
            rx_tag = 8'($urandom()); tx_tag = 8'($urandom());
            rd_req = ($urandom_range(0, 2) != 0);
            if (i % 800 > 400) rd_req = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 15) != 0);
            clear = ($urandom_range(0, 499) == 0);
            rstn = ($urandom_range(0, 599) != 0);
            tick();
        end
        rstn = 1; enable = 1; rd_req = 0;

        // Saturate the drop counter with continuous strobes into a full FIFO
        for (int i = 0; i < 34000; i++) begin
            ftm_time = ftm_time + 48'd3;
            rx_ts_strobe = 1; tx_ts_strobe = 1;
            tick();
        end
        tick(); tick();
        chk("sat_drop", drop_cnt, 16'hFFFF);
        rd_req = 1; repeat (12) tick(); rd_req = 0;
        chk("final_empty", fifo_count, 0);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
